alarm_day: RTL and testbench
============================

Name: alarm_day

Overview:
- Day-of-week register with a weekday alarm decode.
- A 3-bit day counter advances or loads on command. The alarm output is asserted on working days.
- The alarm is computed twice, once by a gate-level decoder and once by a behavioural decoder. A sticky mismatch flag flags any disagreement between the two.
- Sits between the timekeeping block (which issues day_adv at midnight) and the alarm sounder.

Parameters:
- DAY_W, 3, width of the day field; fixed at 3 (values 0..7).
- RESET_DAY, 0, day value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alarm_en  input  1  global alarm enable; 0 forces alarm low.
- day_adv  input  1  advance day by one this cycle.
- day_load  input  1  load day_load_val this cycle.
- day_load_val  input  3  value to load.
- day  output  3  current day register.
- alarm  output  1  registered alarm request for the current day.
- dec_mismatch  output  1  sticky flag: the two decoders disagreed.

Behaviour:
- Encoding: 0=Sunday, 1=Monday .. 6=Saturday, 7=holiday/invalid.
- Decode: alarm_raw = 1 for days 1..5; 0 for days 0, 6 and 7.
  - Gate form: alarm_raw = (~d2 & (d1 | d0)) | (d2 & ~d1 & ~(d1 & d0)). This equals (~d2 & (d1 | d0)) | (d2 & ~d1).
- Reset (rst_n low, asynchronous): day=RESET_DAY, alarm=0, dec_mismatch=0. The outputs hold these values while rst_n is low.
- Next-day logic:
  - day_load has priority over day_adv.
  - day_load=1: day_nxt=day_load_val.
  - day_adv=1 and day_load=0: day_nxt=day+1, modulo 8, so 7 wraps to 0.
  - Neither asserted: day holds.
- Alarm register:
  - alarm <= alarm_en & alarm_raw(day_nxt) at each rising edge.
  - alarm is therefore always aligned with the day value it describes; there is no extra latency relative to day.
  - Deasserting alarm_en clears alarm at the next edge.
- Decoders:
  - Structural decoder: built only from AND/OR/NOT primitives or continuous assigns.
  - Behavioural decoder: a case statement over the 8 day values.
  - Both decoders evaluate day_nxt.
- Mismatch flag:
  - dec_mismatch <= dec_mismatch | (struct_raw != behav_raw) at each edge.
  - Once set, it stays set; only rst_n clears it.
  - The alarm register uses the behavioural result.
- Simultaneous day_load and day_adv: the load wins and the advance is dropped.
- Reset released mid-operation: the first edge after deassertion applies the normal next-state rules starting from RESET_DAY.
- No X propagation: all outputs are driven from registers after reset.

Decomposition:
- Package alarm_day_pkg holds:
  - DAY_W
  - day_t (logic [2:0])
  - named constants DAY_SUN=0 .. DAY_SAT=6, DAY_HOL=7
  - function is_workday(day_t) used by the behavioural decoder.
- One sub-module, alarm_decode_gate: combinational gate-level decoder with inputs d2, d1, d0 and output alarm_raw. It is instantiated once on day_nxt.
- The behavioural decoder and all registers live in alarm_day.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> day=0, alarm=0, dec_mismatch=0. Release with alarm_en=1 and no commands -> outputs stay day=0, alarm=0.
- Full sweep: alarm_en=1, day_adv=1 for 8 cycles from day=0 -> day sequence 1,2,3,4,5,6,7,0. Alarm sequence 1,1,1,1,1,0,0,0. dec_mismatch stays 0 throughout.
- Load priority: day=2, apply day_load=1, day_load_val=6, day_adv=1 together -> day=6, alarm=0. Then load 4 -> day=4, alarm=1.
- Enable gating: day=3, alarm_en 1->0 -> alarm drops to 0 at the next edge with day still 3. Re-enable -> alarm=1 at the following edge.
- Wrap and holiday: load 7 -> alarm=0. Advance -> day=0, alarm=0. Advance -> day=1, alarm=1.
- Async reset mid-run: at day=5, alarm=1, pulse rst_n low between clock edges -> day=0 and alarm=0 immediately, without waiting for an edge. Force an internal decoder disagreement, then pulse reset -> dec_mismatch=1 before the reset pulse and 0 after it.

Source files
------------

// File: rtl/alarm_day_pkg.sv
// Shared types, day encodings and the reference workday decode for the
// day-of-week alarm block.
package alarm_day_pkg;

  localparam int DAY_W = 3;

  typedef logic [DAY_W-1:0] day_t;

  localparam day_t DAY_SUN = 3'd0;
  localparam day_t DAY_MON = 3'd1;
  localparam day_t DAY_TUE = 3'd2;
  localparam day_t DAY_WED = 3'd3;
  localparam day_t DAY_THU = 3'd4;
  localparam day_t DAY_FRI = 3'd5;
  localparam day_t DAY_SAT = 3'd6;
  localparam day_t DAY_HOL = 3'd7;

  // Behavioural reference: Monday..Friday are working days.
  function automatic logic is_workday(day_t d);
    logic r;
    case (d)
      DAY_SUN: r = 1'b0;
      DAY_MON: r = 1'b1;
      DAY_TUE: r = 1'b1;
      DAY_WED: r = 1'b1;
      DAY_THU: r = 1'b1;
      DAY_FRI: r = 1'b1;
      DAY_SAT: r = 1'b0;
      DAY_HOL: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alarm_day_gate.sv
// Gate-level workday decoder: alarm_raw = (~d2 & (d1 | d0)) | (d2 & ~d1).
// Kept primitive-only so it stays an independent cross-check of the case decode.
module alarm_decode_gate (
  input  logic d2,
  input  logic d1,
  input  logic d0,
  output logic alarm_raw
);

  logic n_d2;
  logic n_d1;
  logic d1_or_d0;
  logic low_half;
  logic high_half;

  not u_n_d2  (n_d2, d2);
  not u_n_d1  (n_d1, d1);
  or  u_or10  (d1_or_d0, d1, d0);
  and u_low   (low_half, n_d2, d1_or_d0);
  and u_high  (high_half, d2, n_d1);
  or  u_out   (alarm_raw, low_half, high_half);

endmodule

// File: rtl/alarm_day.sv
// Day-of-week register with registered weekday alarm and a sticky flag that
// trips whenever the gate-level and behavioural decoders disagree.
module alarm_day
  import alarm_day_pkg::*;
#(
  parameter day_t RESET_DAY = DAY_SUN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alarm_en,
  input  logic       day_adv,
  input  logic       day_load,
  input  logic [2:0] day_load_val,
  output logic [2:0] day,
  output logic       alarm,
  output logic       dec_mismatch
);

  day_t day_q, day_d;
  logic alarm_q, alarm_d;
  logic mismatch_q, mismatch_d;
  logic struct_raw;
  logic behav_raw;

  // Both decoders look at the next day so alarm lines up with day, no lag.
  alarm_decode_gate u_dec_gate (
    .d2        (day_d[2]),
    .d1        (day_d[1]),
    .d0        (day_d[0]),
    .alarm_raw (struct_raw)
  );

  assign behav_raw = is_workday(day_d);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    day_d = day_q;
    if (day_load) begin
      day_d = day_load_val;
    end else if (day_adv) begin
      day_d = day_q + day_t'(1);
    end
    alarm_d    = alarm_en & behav_raw;
    mismatch_d = mismatch_q | (struct_raw != behav_raw);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_q      <= RESET_DAY;
      alarm_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      day_q      <= day_d;
      alarm_q    <= alarm_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign day          = day_q;
  assign alarm        = alarm_q;
  assign dec_mismatch = mismatch_q;

endmodule

// File: tb/tb_alarm_day.sv
// Directed-vector bench for alarm_day: sweep, load priority, enable gating,
// wrap, asynchronous reset and the sticky decoder-mismatch flag.
module tb_alarm_day;

  logic       clk;
  logic       rst_n;
  logic       alarm_en;
  logic       day_adv;
  logic       day_load;
  logic [2:0] day_load_val;
  logic [2:0] day;
  logic       alarm;
  logic       dec_mismatch;

  int total = 0;
  int bad   = 0;

  alarm_day dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alarm_en     (alarm_en),
    .day_adv      (day_adv),
    .day_load     (day_load),
    .day_load_val (day_load_val),
    .day          (day),
    .alarm        (alarm),
    .dec_mismatch (dec_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic adv, input logic ld, input logic [2:0] val);
    day_adv      = adv;
    day_load     = ld;
    day_load_val = val;
  endtask

  // Expected sequence when advancing from Sunday with alarm enabled.
  logic [2:0] sweep_day   [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic       sweep_alarm [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    // Reset with random inputs
    rst_n        = 1'b0;
    alarm_en     = 1'($urandom_range(1));
    day_adv      = 1'($urandom_range(1));
    day_load     = 1'($urandom_range(1));
    day_load_val = 3'($urandom_range(7));
    step();
    step();
    check("rst_day", 8'(day), 8'd0);
    check("rst_alarm", 8'(alarm), 8'd0);
    check("rst_mismatch", 8'(dec_mismatch), 8'd0);

    rst_n    = 1'b1;
    alarm_en = 1'b1;
    cmd(1'b0, 1'b0, 3'd0);
    step();
    check("rel_day", 8'(day), 8'd0);
    check("rel_alarm", 8'(alarm), 8'd0);

    // Full sweep
    cmd(1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("sweep_day%0d", i), 8'(day), 8'(sweep_day[i]));
      check($sformatf("sweep_alarm%0d", i), 8'(alarm), 8'(sweep_alarm[i]));
    end
    check("sweep_mismatch", 8'(dec_mismatch), 8'd0);

    // Load priority over advance
    cmd(1'b0, 1'b1, 3'd2);
    step();
    check("ld2_day", 8'(day), 8'd2);
    cmd(1'b1, 1'b1, 3'd6);
    step();
    check("ldadv_day", 8'(day), 8'd6);
    check("ldadv_alarm", 8'(alarm), 8'd0);
    cmd(1'b0, 1'b1, 3'd4);
    step();
    check("ld4_day", 8'(day), 8'd4);
    check("ld4_alarm", 8'(alarm), 8'd1);

    // Enable gating
    cmd(1'b0, 1'b1, 3'd3);
    step();
    check("ld3_alarm", 8'(alarm), 8'd1);
    cmd(1'b0, 1'b0, 3'd0);
    alarm_en = 1'b0;
    step();
    check("dis_day", 8'(day), 8'd3);
    check("dis_alarm", 8'(alarm), 8'd0);
    alarm_en = 1'b1;
    step();
    check("en_day", 8'(day), 8'd3);
    check("en_alarm", 8'(alarm), 8'd1);

    // Wrap through holiday
    cmd(1'b0, 1'b1, 3'd7);
    step();
    check("hol_day", 8'(day), 8'd7);
    check("hol_alarm", 8'(alarm), 8'd0);
    cmd(1'b1, 1'b0, 3'd0);
    step();
    check("wrap_day", 8'(day), 8'd0);
    check("wrap_alarm", 8'(alarm), 8'd0);
    step();
    check("mon_day", 8'(day), 8'd1);
    check("mon_alarm", 8'(alarm), 8'd1);

    // Asynchronous reset between edges
    cmd(1'b0, 1'b1, 3'd5);
    step();
    check("ld5_day", 8'(day), 8'd5);
    check("ld5_alarm", 8'(alarm), 8'd1);
    cmd(1'b0, 1'b0, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_day", 8'(day), 8'd0);
    check("arst_alarm", 8'(alarm), 8'd0);
    #1;
    rst_n = 1'b1;
    cmd(1'b1, 1'b0, 3'd0);
    step();
    check("post_rst_day", 8'(day), 8'd1);
    check("post_rst_alarm", 8'(alarm), 8'd1);

    // Forced decoder disagreement: day holds at Monday, gate output forced low
    cmd(1'b0, 1'b0, 3'd0);
    check("pre_force_mismatch", 8'(dec_mismatch), 8'd0);
    force dut.struct_raw = 1'b0;
    step();
    check("force_mismatch", 8'(dec_mismatch), 8'd1);
    check("force_alarm", 8'(alarm), 8'd1);
    release dut.struct_raw;
    step();
    check("sticky_mismatch", 8'(dec_mismatch), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("clr_mismatch", 8'(dec_mismatch), 8'd0);
    #1;
    rst_n = 1'b1;
    step();
    check("after_clr_mismatch", 8'(dec_mismatch), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
